// File: rtl/cherry_float_pkg.sv
// Shared definitions for the cherry float units: 1 sign, 8 exponent, MANTISSA
// fraction bits, flush-to-zero, canonical NaN. Also holds the divider FSM states.
package cherry_float_pkg;

  localparam int EXPONENT = 8;
  localparam int BIAS     = 127;
  localparam logic [EXPONENT-1:0] MAX_EXPONENT = 8'hFF;

  // Canonical NaN at the default fraction width (MANTISSA = 9).
  localparam logic [17:0] CANONICAL_NAN = 18'h3FF00;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORMAL,
    FP_INF,
    FP_NAN
  } fp_class_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_PACK,
    S_DONE
  } div_state_t;

  function automatic logic sign_field(input logic [31:0] word, input int mantissa);
    return word[mantissa + EXPONENT];
  endfunction

  function automatic logic [EXPONENT-1:0] exp_field(input logic [31:0] word, input int mantissa);
    return EXPONENT'(word >> mantissa);
  endfunction

  // Exponent 0 is zero regardless of fraction; all-ones splits on the fraction.
  function automatic fp_class_t class_of(input logic [EXPONENT-1:0] expo, input logic frac_nz);
    if (expo == '0) return FP_ZERO;
    if (expo == MAX_EXPONENT) return frac_nz ? FP_NAN : FP_INF;
    return FP_NORMAL;
  endfunction

endpackage

// File: rtl/fp_div_if.sv
// Operand/result handshake bundle for fp_div.
interface fp_div_if #(
  parameter int MANTISSA = 9
);
  localparam int W = MANTISSA + 9;

  // A transfer happens on a rising edge where valid and ready are both high.
  // The producer holds valid and its payload stable until that edge; the
  // consumer may change ready freely. in_* carries operands, out_* the quotient.
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] OUT;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, OUT
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, OUT
  );

endinterface

// File: rtl/fp_classify.sv
// Combinational unpack of a cherry float word into sign/exponent/fraction and
// its class. Shared by the multiplier and the divider.
module fp_classify
  import cherry_float_pkg::*;
#(
  parameter int MANTISSA = 9
) (
  input  logic [MANTISSA+8:0]   word,
  output logic                  sign,
  output logic [EXPONENT-1:0]   expo,
  output logic [MANTISSA-1:0]   frac,
  output fp_class_t             cls
);

  assign sign = sign_field(32'(word), MANTISSA);
  assign expo = exp_field(32'(word), MANTISSA);
  assign frac = word[MANTISSA-1:0];
  assign cls  = class_of(expo, |frac);

endmodule

// File: rtl/fp_div.sv
// Iterative restoring divider for cherry float, OUT = A / B, truncating.
// Define FP_DIV_RNE_EN for round-to-nearest-even (one extra quotient bit).
module fp_div
  import cherry_float_pkg::*;
#(
  parameter int MANTISSA = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  fp_div_if.slave    io,
  output div_state_t dbg_state
);

  localparam int W  = MANTISSA + 9;
  localparam int RW = MANTISSA + 2;
`ifdef FP_DIV_RNE_EN
  localparam int QBITS = MANTISSA + 3;
`else
  localparam int QBITS = MANTISSA + 2;
`endif
  localparam int CW = $clog2(QBITS + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(QBITS - 1);
  localparam logic [W-1:0]  NAN_WORD  = {1'b1, MAX_EXPONENT, 1'b1, {(MANTISSA-1){1'b0}}};

  logic                  a_sign, b_sign;
  logic [EXPONENT-1:0]   a_exp, b_exp;
  logic [MANTISSA-1:0]   a_frac, b_frac;
  fp_class_t             a_cls, b_cls;

  fp_classify #(.MANTISSA(MANTISSA)) u_cls_a (
    .word(io.A), .sign(a_sign), .expo(a_exp), .frac(a_frac), .cls(a_cls)
  );

  fp_classify #(.MANTISSA(MANTISSA)) u_cls_b (
    .word(io.B), .sign(b_sign), .expo(b_exp), .frac(b_frac), .cls(b_cls)
  );

  div_state_t            state_q, state_d;
  logic                  sign_q, sign_d;
  logic [EXPONENT-1:0]   exp_a_q, exp_a_d, exp_b_q, exp_b_d;
  logic [MANTISSA:0]     divisor_q, divisor_d;
  logic [RW-1:0]         rem_q, rem_d;
  logic [QBITS-1:0]      quo_q, quo_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  special_q, special_d;
  logic [W-1:0]          special_res_q, special_res_d;
  logic [W-1:0]          out_q, out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;

  // Special-operand decode straight off the incoming operands.
  logic         spec_hit;
  logic [W-1:0] spec_res;
  logic         sign_in;

  assign sign_in = a_sign ^ b_sign;

  always_comb begin
    spec_hit = 1'b1;
    spec_res = '0;
    if (a_cls == FP_NAN || b_cls == FP_NAN ||
        (a_cls == FP_INF && b_cls == FP_INF) ||
        (a_cls == FP_ZERO && b_cls == FP_ZERO)) begin
      spec_res = NAN_WORD;
    end else if (a_cls == FP_INF || b_cls == FP_ZERO) begin
      spec_res = {sign_in, MAX_EXPONENT, {MANTISSA{1'b0}}};
    end else if (a_cls == FP_ZERO || b_cls == FP_INF) begin
      spec_res = {sign_in, {(W-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // One restoring step: subtract when it fits, then shift for the next bit.
  logic [RW-1:0] div_ext, rem_sub;
  logic          step_ge;

  assign div_ext = {1'b0, divisor_q};
  assign step_ge = rem_q >= div_ext;
  assign rem_sub = step_ge ? (rem_q - div_ext) : rem_q;

  logic signed [9:0]   exp_diff, exp_adj;
  logic [MANTISSA-1:0] frac_n, frac_f;
  logic [W-1:0]        pack_res;
`ifdef FP_DIV_RNE_EN
  logic                guard, sticky, carry;
  logic [MANTISSA-1:0] frac_r;
`endif

  always_comb begin
    exp_diff = $signed({2'b00, exp_a_q}) - $signed({2'b00, exp_b_q});
    if (quo_q[QBITS-1]) begin
      frac_n  = quo_q[QBITS-2 -: MANTISSA];
      exp_adj = exp_diff + $signed(10'(BIAS));
    end else begin
      frac_n  = quo_q[QBITS-3 -: MANTISSA];
      exp_adj = exp_diff + $signed(10'(BIAS - 1));
    end
    frac_f = frac_n;
`ifdef FP_DIV_RNE_EN
    if (quo_q[QBITS-1]) begin
      guard  = quo_q[1];
      sticky = quo_q[0] | (|rem_q);
    end else begin
      guard  = quo_q[0];
      sticky = |rem_q;
    end
    {carry, frac_r} = {1'b0, frac_n} + {{MANTISSA{1'b0}}, guard & (sticky | frac_n[0])};
    frac_f = frac_r;
    // Mantissa rolled over to 2.0: fraction is already zero, bump the exponent.
    if (carry) exp_adj = exp_adj + 10'sd1;
`endif
    if (exp_adj <= 10'sd0) begin
      pack_res = '0;
    end else if (exp_adj >= 10'sd255) begin
      pack_res = {sign_q, MAX_EXPONENT, {MANTISSA{1'b0}}};
    end else begin
      pack_res = {sign_q, exp_adj[EXPONENT-1:0], frac_f};
    end
  end

  always_comb begin
    state_d       = state_q;
    sign_d        = sign_q;
    exp_a_d       = exp_a_q;
    exp_b_d       = exp_b_q;
    divisor_d     = divisor_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    cnt_d         = cnt_q;
    special_d     = special_q;
    special_res_d = special_res_q;
    out_d         = out_q;
    out_valid_d   = out_valid_q;
    in_ready_d    = in_ready_q;
    case (state_q)
      S_IDLE: begin
        if (io.in_valid) begin
          sign_d        = sign_in;
          exp_a_d       = a_exp;
          exp_b_d       = b_exp;
          divisor_d     = {1'b1, b_frac};
          rem_d         = {1'b0, 1'b1, a_frac};
          quo_d         = '0;
          cnt_d         = '0;
          special_d     = spec_hit;
          special_res_d = spec_res;
          in_ready_d    = 1'b0;
          // Specials skip the iterations but still register OUT through PACK.
          state_d       = spec_hit ? S_PACK : S_DIV;
        end
      end
      S_DIV: begin
        rem_d = {rem_sub[RW-2:0], 1'b0};
        quo_d = {quo_q[QBITS-2:0], step_ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) state_d = S_PACK;
      end
      S_PACK: begin
        out_d       = special_q ? special_res_q : pack_res;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (io.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sign_q        <= 1'b0;
      exp_a_q       <= '0;
      exp_b_q       <= '0;
      divisor_q     <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      cnt_q         <= '0;
      special_q     <= 1'b0;
      special_res_q <= '0;
      out_q         <= '0;
      out_valid_q   <= 1'b0;
      in_ready_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      sign_q        <= sign_d;
      exp_a_q       <= exp_a_d;
      exp_b_q       <= exp_b_d;
      divisor_q     <= divisor_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      cnt_q         <= cnt_d;
      special_q     <= special_d;
      special_res_q <= special_res_d;
      out_q         <= out_d;
      out_valid_q   <= out_valid_d;
      in_ready_q    <= in_ready_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.OUT       = out_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_fp_div.sv
// Directed bench for fp_div: arithmetic model of the float quotient, a
// scoreboard checked every cycle OUT is valid, and literal expectations.
module tb_fp_div;
  import cherry_float_pkg::*;

  localparam int M = 9;
  localparam int W = M + 9;
`ifdef FP_DIV_RNE_EN
  localparam int NORM_LAT = M + 4;
  localparam logic [W-1:0] THIRD_Q = 18'h0FAAB;
`else
  localparam int NORM_LAT = M + 3;
  localparam logic [W-1:0] THIRD_Q = 18'h0FAAA;
`endif

  logic       clk;
  logic       rst_n;
  div_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  fp_div_if #(.MANTISSA(M)) bus ();

  fp_div #(.MANTISSA(M)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io(bus),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- model ----------------
  function automatic logic [W-1:0] model_div(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] res;
    logic s;
    int ea, eb, fa, fb, e;
    longint ma, mb, num, q, r;
    bit a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    s  = a[W-1] ^ b[W-1];
    ea = int'(a[W-2:M]);
    eb = int'(b[W-2:M]);
    fa = int'(a[M-1:0]);
    fb = int'(b[M-1:0]);
    a_zero = (ea == 0);
    a_inf  = (ea == 255) && (fa == 0);
    a_nan  = (ea == 255) && (fa != 0);
    b_zero = (eb == 0);
    b_inf  = (eb == 255) && (fb == 0);
    b_nan  = (eb == 255) && (fb != 0);
    res = '0;
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
      res[W-1] = 1'b1;
      res[W-2:M] = 8'hFF;
      res[M-1] = 1'b1;
      return res;
    end
    if (a_inf || b_zero) begin
      res[W-1] = s;
      res[W-2:M] = 8'hFF;
      return res;
    end
    if (a_zero || b_inf) begin
      res[W-1] = s;
      return res;
    end
    ma = longint'((1 << M) + fa);
    mb = longint'((1 << M) + fb);
    e  = ea - eb + 127;
    // Scale the dividend so the quotient lands in [1, 2).
    if (ma < mb) begin
      ma = ma * 2;
      e  = e - 1;
    end
    num = ma << M;
    q   = num / mb;
    r   = num % mb;
`ifdef FP_DIV_RNE_EN
    if ((2 * r > mb) || ((2 * r == mb) && (q % 2 == 1))) q = q + 1;
    if (q == longint'(1 << (M + 1))) begin
      q = longint'(1 << M);
      e = e + 1;
    end
`else
    if (r < 0) q = 0;
`endif
    if (e <= 0) return '0;
    res[W-1] = s;
    if (e >= 255) begin
      res[W-2:M] = 8'hFF;
      return res;
    end
    res[W-2:M] = 8'(e);
    res[M-1:0] = M'(q - longint'(1 << M));
    return res;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid actual=%0h required=none", bus.OUT);
      end else begin
        check("scoreboard_out", 32'(bus.OUT), 32'(exp_q[0]));
        if (bus.out_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] lit, input int lat_req, input int hold);
    int  waited;
    int  lat;
    bit  busy_ok;
    bit  stable;
    check({name, "_model"}, 32'(model_div(a, b)), 32'(lit));
    bus.A = a;
    bus.B = b;
    bus.in_valid = 1'b1;
    waited = 0;
    while (1) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) break;
      waited++;
      if (waited > 100) begin
        check({name, "_accept_timeout"}, 32'(waited), 32'(0));
        bus.in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    exp_q.push_back(model_div(a, b));
    busy_ok = 1'b1;
    lat = 0;
    while (1) begin
      if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
      if (bus.out_valid === 1'b1) break;
      if (lat > 100) break;
    end
    check({name, "_latency"}, 32'(lat), 32'(lat_req));
    check({name, "_busy"}, 32'(busy_ok), 32'(1));
    check({name, "_out"}, 32'(bus.OUT), 32'(lit));
    if (hold > 0) begin
      bus.A = b;
      bus.B = a;
      bus.in_valid = 1'b1;
      stable = 1'b1;
      repeat (hold) begin
        @(posedge clk);
        #1;
        if (bus.out_valid !== 1'b1 || bus.OUT !== lit || bus.in_ready !== 1'b0 ||
            dbg_state != S_DONE) stable = 1'b0;
      end
      check({name, "_stall_stable"}, 32'(stable), 32'(1));
      bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({name, "_release"}, {30'd0, bus.out_valid, bus.in_ready}, 32'h1);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_in_ready"}, 32'(bus.in_ready), 32'(1));
    check({name, "_out_valid"}, 32'(bus.out_valid), 32'(0));
    check({name, "_out"}, 32'(bus.OUT), 32'(0));
    check({name, "_state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit quiet;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("six_by_two",   18'h10300, 18'h10000, 18'h10100, NORM_LAT, 0);
    run_op("three_by_two", 18'h10100, 18'h10000, 18'h0FF00, NORM_LAT, 0);
    run_op("one_by_three", 18'h0FE00, 18'h10100, THIRD_Q,   NORM_LAT, 0);
    run_op("pos_by_zero",  18'h0FE00, 18'h00000, 18'h1FE00, 1, 0);
    run_op("neg_by_zero",  18'h2FE00, 18'h00000, 18'h3FE00, 1, 0);
    run_op("zero_by_zero", 18'h00000, 18'h00000, CANONICAL_NAN, 1, 0);
    run_op("inf_by_inf",   18'h1FE00, 18'h1FE00, 18'h3FF00, 1, 0);
    run_op("zero_by_neg",  18'h00000, 18'h30100, 18'h20000, 1, 0);
    run_op("underflow",    18'h00200, 18'h10000, 18'h00000, NORM_LAT, 0);
    run_op("overflow",     18'h1FC00, 18'h0FC00, 18'h1FE00, NORM_LAT, 0);
    run_op("backpressure", 18'h10300, 18'h10000, 18'h10100, NORM_LAT, 5);

    // Abort an operation partway through its iterations.
    bus.A = 18'h10300;
    bus.B = 18'h10000;
    bus.in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0) quiet = 1'b0;
    end
    check("aborted_no_valid", 32'(quiet), 32'(1));
    run_op("after_reset", 18'h10100, 18'h10000, 18'h0FF00, NORM_LAT, 0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
